// File: rtl/mac_result_collector.sv
// Issue/collect stage around the MAC: forwards instructions, stalls the MAC, queues tagged results with overflow flags.
// A tagged result is pushed 3 edges after its accept (given two more accepts); in_ready drops while in-flight tags could overfill the FIFO.
module mac_result_collector #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_instruction,
  input  logic [15:0]              in_multiplier,
  input  logic [15:0]              in_multiplicand,
  input  logic                     in_emit,
  output logic [2:0]               mac_instruction,
  output logic [15:0]              mac_multiplier,
  output logic [15:0]              mac_multiplicand,
  output logic                     mac_stall,
  input  logic [31:0]              mac_result,
  input  logic [7:0]               mac_protect,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [7:0]               out_protect,
  output logic [2:0]               out_op,
  output logic [1:0]               out_ovf,
  output logic [$clog2(DEPTH):0]   out_level
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = LW + 2;
  localparam logic [RW-1:0] DEPTH_R  = RW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  protect;
    logic [2:0]  op;
    logic [1:0]  ovf;
  } entry_t;

  logic          e1_q, e2_q, pend_q, pend_d;
  logic [2:0]    op1_q, op2_q, opp_q;
  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] reserved, need;
  logic          accept, push, pop;
  logic [1:0]    push_ovf;
  entry_t        push_entry, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Reservations count every tag still travelling toward the FIFO, so a full FIFO never meets a pending push.
  assign reserved = RW'(level_q) + RW'(pend_q) + RW'(e1_q) + RW'(e2_q);
  assign need     = reserved + RW'(in_emit);
  assign in_ready = (need <= DEPTH_R);
  assign accept   = in_valid && in_ready;
  assign mac_stall = !accept;

  assign mac_instruction  = in_instruction;
  assign mac_multiplier   = in_multiplier;
  assign mac_multiplicand = in_multiplicand;

  always_comb begin
    push_ovf = 2'b00;
    case (opp_q)
      3'd0, 3'd1, 3'd2: push_ovf[0] = (mac_protect != {8{mac_result[31]}});
      3'd4, 3'd5, 3'd6: begin
        push_ovf[0] = (mac_protect[3:0] != {4{mac_result[15]}});
        push_ovf[1] = (mac_protect[7:4] != {4{mac_result[31]}});
      end
      default: push_ovf = 2'b00;
    endcase
  end

  assign push_entry = '{result: mac_result, protect: mac_protect, op: opp_q, ovf: push_ovf};
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    push     = pend_q;
    pop      = out_valid && out_ready;
    pend_d   = accept && e2_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e1_q     <= 1'b0;
      e2_q     <= 1'b0;
      pend_q   <= 1'b0;
      op1_q    <= 3'd0;
      op2_q    <= 3'd0;
      opp_q    <= 3'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (accept) begin
        e1_q  <= in_emit;
        op1_q <= in_instruction;
        e2_q  <= e1_q;
        op2_q <= op1_q;
        if (e2_q) opp_q <= op2_q;
      end
      pend_q <= pend_d;
      if (push) mem_q[wr_ptr_q] <= push_entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign out_valid   = (level_q != '0);
  assign out_result  = head.result;
  assign out_protect = head.protect;
  assign out_op      = head.op;
  assign out_ovf     = head.ovf;
  assign out_level   = level_q;
endmodule

// File: tb/tb_mac_result_collector.sv
// Bench for mac_result_collector: a behavioural two-stage MAC drives the DUT; a scoreboard checks every drained entry.
module tb_mac_result_collector;
  localparam int DEPTH = 4;
  localparam longint W32 = 64'sh80000000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_emit = 1'b1;
  logic [2:0]  in_instruction = '0;
  logic [15:0] in_multiplier = '0, in_multiplicand = '0;
  logic [2:0]  mac_instruction;
  logic [15:0] mac_multiplier, mac_multiplicand;
  logic        mac_stall;
  logic [31:0] mac_result;
  logic [7:0]  mac_protect;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_result;
  logic [7:0]  out_protect;
  logic [2:0]  out_op;
  logic [1:0]  out_ovf;
  logic [$clog2(DEPTH):0] out_level;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  logic [44:0] exp_q[$];
  logic [39:0] ref_acc = '0;

  mac_result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_multiplier(in_multiplier),
    .in_multiplicand(in_multiplicand), .in_emit(in_emit),
    .mac_instruction(mac_instruction), .mac_multiplier(mac_multiplier),
    .mac_multiplicand(mac_multiplicand), .mac_stall(mac_stall),
    .mac_result(mac_result), .mac_protect(mac_protect),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_protect(out_protect), .out_op(out_op), .out_ovf(out_ovf), .out_level(out_level)
  );

  always #5 clk = ~clk;

  // Accumulator held as {protect, result}; dual-lane ops view it as two 20-bit lanes.
  function automatic logic [39:0] mac_step(input logic [39:0] acc, input logic [2:0] op,
                                           input logic [15:0] a, input logic [15:0] b);
    logic signed [39:0] p;
    logic signed [19:0] l, h, pl, ph;
    logic [39:0] r;
    p  = $signed(a) * $signed(b);
    pl = $signed(a[7:0]) * $signed(b[7:0]);
    ph = $signed(a[15:8]) * $signed(b[15:8]);
    l  = $signed({acc[35:32], acc[15:0]});
    h  = $signed({acc[39:36], acc[31:16]});
    r  = '0;
    case (op)
      3'd0: r = acc;
      3'd1: r = p;
      3'd2: r = acc + p;
      3'd4: begin l = l + pl; h = h + ph; end
      3'd5: begin l = pl; h = ph; end
      3'd6: begin l = l - pl; h = h - ph; end
      default: r = '0;
    endcase
    if (op >= 3'd4 && op <= 3'd6) r = {h[19:16], l[19:16], h[15:0], l[15:0]};
    return r;
  endfunction

  function automatic logic [1:0] ref_ovf(input logic [2:0] op, input logic [39:0] v);
    longint full;
    int lo, hi;
    full = longint'($signed(v));
    lo   = int'($signed({v[35:32], v[15:0]}));
    hi   = int'($signed({v[39:36], v[31:16]}));
    if (op <= 3'd2) return {1'b0, (full < -W32) || (full >= W32)};
    if (op >= 3'd4 && op <= 3'd6)
      return {(hi < -32768) || (hi > 32767), (lo < -32768) || (lo > 32767)};
    return 2'b00;
  endfunction

  // Behavioural MAC: advances only when not stalled, result valid two accepts after issue.
  logic [34:0] s1 = '0, s2 = '0;
  logic [39:0] acc = '0;
  always @(posedge clk) begin
    if (!mac_stall) begin
      s1  <= {mac_instruction, mac_multiplier, mac_multiplicand};
      s2  <= s1;
      acc <= mac_step(acc, s2[34:32], s2[31:16], s2[15:0]);
    end
  end
  assign mac_result  = acc[31:0];
  assign mac_protect = acc[39:32];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  initial forever begin
    @(negedge clk);
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got %h expected none", {out_result, out_protect, out_op, out_ovf});
      end else begin
        chk("fifo_entry", {out_result, out_protect, out_op, out_ovf}, exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic e, output int waited);
    bit ok;
    in_valid = 1'b1; in_instruction = op; in_multiplier = a; in_multiplicand = b; in_emit = e;
    ok = 0;
    waited = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        ref_acc = mac_step(ref_acc, op, a, b);
        if (e) exp_q.push_back({ref_acc[31:0], ref_acc[39:32], op, ref_ovf(op, ref_acc)});
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got no accept expected accept within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic pads(input int n);
    int w;
    for (int i = 0; i < n; i++) issue(3'd0, 16'h0, 16'h0, 1'b0, w);
  endtask

  task automatic drain();
    rdy_mode = 1;
    out_ready = 1'b1;
    for (int t = 0; t < 500 && (out_level != 0 || exp_q.size() != 0); t++) @(negedge clk);
    chk("drain_level", out_level, 0);
    chk("drain_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h8080;
      3: return 16'h7F7F;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    in_instruction = 3'd5; in_multiplier = 16'h1234; in_multiplicand = 16'hBEEF;
    repeat (2) next_edge();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_level", out_level, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_protect", out_protect, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mac_stall", mac_stall, 1);
    chk("pass_through", {mac_instruction, mac_multiplier, mac_multiplicand}, {3'd5, 16'h1234, 16'hBEEF});
    next_edge();

    // Single emit, with latency check.
    issue(3'd1, 16'd3, 16'd4, 1'b1, w);
    pads(2);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    next_edge();
    chk("lat_valid", out_valid, 1);
    chk("single_head", {out_result, out_protect, out_op, out_ovf}, {32'h0000000C, 8'h00, 3'd1, 2'b00});
    drain();

    // Full-word overflow.
    issue(3'd1, 16'h8000, 16'h8000, 1'b0, w);
    issue(3'd2, 16'h8000, 16'h8000, 1'b1, w);
    pads(2);
    next_edge();
    chk("fullovf_head", {out_result, out_protect, out_op, out_ovf}, {32'h80000000, 8'h00, 3'd2, 2'b01});
    drain();

    // Dual lane.
    issue(3'd5, 16'h7F80, 16'h7F80, 1'b1, w);
    pads(2);
    next_edge();
    chk("dual_head", {out_result, out_protect, out_op, out_ovf}, {32'h3F014000, 8'h00, 3'd5, 2'b00});
    drain();

    // Backpressure: fill the FIFO, then a fifth emit must wait for one pop.
    rdy_mode = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1, w);
    pads(2);
    next_edge();
    chk("bp_level_full", out_level, 4);
    in_valid = 1'b1; in_instruction = 3'd1; in_multiplier = 16'd7; in_multiplicand = 16'd9; in_emit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_mac_stall", mac_stall, 1);
      next_edge();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_not_credited", in_ready, 0);
    next_edge();
    out_ready = 1'b0;
    issue(3'd1, 16'd7, 16'd9, 1'b1, w);
    chk("bp_accept_after_pop", w, 0);
    pads(2);
    drain();

    // Idle gap: the pending tag waits for two later accepts.
    issue(3'd1, 16'hFFFF, 16'd5, 1'b1, w);
    pads(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_stall", mac_stall, 1);
      chk("idle_no_push", out_valid, 0);
      next_edge();
    end
    pads(1);
    @(negedge clk);
    chk("idle_pend_not_pushed", out_valid, 0);
    next_edge();
    chk("idle_pushed", out_valid, 1);
    drain();

    // Reset with two stored entries and a pending tag.
    rdy_mode = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b1, w);
    pads(2);
    chk("pre_reset_level", out_level, 2);
    reset_n = 1'b0;
    exp_q.delete();
    next_edge();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_level", out_level, 0);
    next_edge();

    // Randomised traffic with random downstream readiness.
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      issue(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) next_edge();
    end
    pads(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
